charlieplex_scanner: RTL and testbench

//  Refresh controller for a charlieplexed LED matrix. Holds a 1-bit-per-LED bitmap, walks all

---
 rtl/charlieplex_scanner_pkg.sv | 7 +
 rtl/charlieplex_scanner_charlieplexer.sv | 21 ++
 rtl/charlieplex_scanner.sv | 89 ++++++++
 tb/tb_charlieplex_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/charlieplex_scanner_pkg.sv
// charlieplex_scanner_pkg: scan state encoding and parameter helpers
package charlieplex_scanner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, DRIVE = 2'd2} state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/charlieplex_scanner_charlieplexer.sv
// charlieplexer: decodes an LED index into one high pin and one low pin
module charlieplexer #(
  parameter int PINCOUNT = 17,
  localparam int LEDCOUNT = PINCOUNT * (PINCOUNT - 1),
  localparam int INDEXBITS = $clog2(LEDCOUNT)
) (
  input  logic [INDEXBITS-1:0] index,
  input  logic                 enable,
  output logic [PINCOUNT-1:0]  out_en,
  output logic [PINCOUNT-1:0]  out_value
);
  logic [INDEXBITS-1:0] hi, r, lo;
  // index = hi*(PINCOUNT-1) + r; the low pin skips over the high pin
  always_comb begin
    hi = index / INDEXBITS'(PINCOUNT - 1);
    r = index % INDEXBITS'(PINCOUNT - 1);
    lo = r < hi ? r : r + INDEXBITS'(1);
    out_en = enable ? (PINCOUNT'(1) << hi) | (PINCOUNT'(1) << lo) : '0;
    out_value = enable ? PINCOUNT'(1) << hi : '0;
  end
endmodule

// File: rtl/charlieplex_scanner.sv
// charlieplex_scanner: round-robin refresh of a charlieplexed LED bitmap (option: CHARLIEPLEX_SCANNER_SKIP_DARK_EN)
module charlieplex_scanner
  import charlieplex_scanner_pkg::*;
#(
  parameter int PINCOUNT = 17,
  parameter int DWELL = 1000,
  parameter int DEADTIME = 4,
  localparam int LEDCOUNT = PINCOUNT * (PINCOUNT - 1),
  localparam int INDEXBITS = $clog2(LEDCOUNT),
  localparam int CW = $clog2(max2(DWELL, DEADTIME) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 wr_en,
  input  logic [INDEXBITS-1:0] wr_addr,
  input  logic                 wr_data,
  output logic                 frame_start,
  output logic [PINCOUNT-1:0]  out_en,
  output logic [PINCOUNT-1:0]  out_value
);
  state_t state, state_n;
  logic [INDEXBITS-1:0] index, index_n, inc;
  logic enable, enable_n;
  logic [CW-1:0] counter, counter_n;
  logic [LEDCOUNT-1:0] bitmap;
  assign inc = index == INDEXBITS'(LEDCOUNT - 1) ? '0 : index + INDEXBITS'(1);
`ifdef CHARLIEPLEX_SCANNER_SKIP_DARK_EN
  assign frame_start = index == '0 &&
    ((state == DRIVE && counter == CW'(DWELL - 1)) || (state == DEAD && !bitmap[0]));
`else
  assign frame_start = index == '0 && state == DRIVE && counter == CW'(DWELL - 1);
`endif
  // host writes land on the next edge; out-of-range addresses are dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) bitmap <= '0;
    else if (wr_en && {1'b0, wr_addr} < (INDEXBITS + 1)'(LEDCOUNT)) bitmap[wr_addr] <= wr_data;
  // scan state register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      index <= '0;
      enable <= 1'b0;
      counter <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
      enable <= enable_n;
      counter <= counter_n;
    end
  // dead time then dwell per slot; index only moves while enable is low
  always_comb begin
    state_n = state;
    index_n = index;
    enable_n = enable;
    counter_n = counter;
    if (!run) begin
      state_n = IDLE;
      index_n = '0;
      enable_n = 1'b0;
      counter_n = '0;
    end else if (state == IDLE) begin
      state_n = DEAD;
      counter_n = CW'(DEADTIME - 1);
`ifdef CHARLIEPLEX_SCANNER_SKIP_DARK_EN
    end else if (state == DEAD && !bitmap[index]) begin
      index_n = inc;
      counter_n = CW'(DEADTIME - 1);
`endif
    end else if (counter != '0) begin
      counter_n = counter - CW'(1);
    end else if (state == DEAD) begin
      state_n = DRIVE;
      enable_n = bitmap[index];
      counter_n = CW'(DWELL - 1);
    end else begin
      state_n = DEAD;
      enable_n = 1'b0;
      index_n = inc;
      counter_n = CW'(DEADTIME - 1);
    end
  end
  charlieplexer #(.PINCOUNT(PINCOUNT)) u_cp (
    .index(index),
    .enable(enable),
    .out_en(out_en),
    .out_value(out_value)
  );
endmodule

// File: tb/tb_charlieplex_scanner.sv
// tb_charlieplex_scanner: directed checks of the scan sequence, pin decode and corner cases
module tb_charlieplex_scanner;
  localparam int P = 3, DW = 4, DT = 2, N = 6, IB = 3;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, wr_en = 1'b0, wr_data = 1'b0;
  logic [IB-1:0] wr_addr = '0;
  logic frame_start;
  logic [P-1:0] out_en, out_value;
  int errors = 0, checks = 0;
  typedef struct {
    logic [P-1:0] en;
    logic [P-1:0] val;
  } vec_t;
  vec_t tbl[N];

  always #5 clk = ~clk;

  charlieplex_scanner #(.PINCOUNT(P), .DWELL(DW), .DEADTIME(DT)) dut (
    .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .out_en(out_en), .out_value(out_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_en"}, 32'(out_en), 0);
    check({name, "_val"}, 32'(out_value), 0);
    check({name, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic write(input int a, input logic d);
    wr_en = 1'b1;
    wr_addr = IB'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fs;
    int n = 0;
    while (!frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame_start", 32'(frame_start), 1);
  endtask

  task automatic check_frame(input logic [N-1:0] mask, input int wr_at);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < DW; k++) begin
        check($sformatf("slot%0d_en", i), 32'(out_en), 32'(mask[i] ? tbl[i].en : '0));
        check($sformatf("slot%0d_val", i), 32'(out_value), 32'(mask[i] ? tbl[i].val : '0));
        check($sformatf("slot%0d_fs", i), 32'(frame_start), 32'(i == 0 && k == 0));
        if (i == wr_at) begin
          wr_en = k == 0;
          wr_addr = IB'(i);
          wr_data = 1'b0;
        end
        @(negedge clk);
      end
      for (int k = 0; k < DT; k++) begin
        check_idle($sformatf("dead%0d", i));
        @(negedge clk);
      end
    end
    check("frame_period", 32'(frame_start), 1);
  endtask

  task automatic measure(output int n, output int lit);
    n = 0;
    lit = 0;
    do begin
      if (out_en != '0) lit++;
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
  endtask

  initial begin
    int n, lit;
    tbl = '{'{3'b011, 3'b001}, '{3'b101, 3'b001}, '{3'b011, 3'b010},
            '{3'b110, 3'b010}, '{3'b101, 3'b100}, '{3'b110, 3'b100}};
    #12;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("idle_run0");
    end
`ifdef CHARLIEPLEX_SCANNER_SKIP_DARK_EN
    write(3, 1'b1);
    run = 1'b1;
    wait_fs;
    for (int f = 0; f < 2; f++) begin
      measure(n, lit);
      check("skip_period", n, 11);
      check("skip_lit", lit, 4);
    end
    run = 1'b0;
    write(3, 1'b0);
    run = 1'b1;
    wait_fs;
    measure(n, lit);
    check("skip_dark_period", n, 6);
    check("skip_dark_lit", lit, 0);
`else
    for (int i = 0; i < N; i++) write(i, 1'b1);
    write(7, 1'b1);
    run = 1'b1;
    wait_fs;
    check_frame('1, -1);
    check_frame('1, 1);
    check_frame(6'b111101, -1);
    run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) write(i, i == 2);
    run = 1'b1;
    wait_fs;
    check_frame(6'b000100, -1);
    run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) write(i, 1'b1);
    run = 1'b1;
    wait_fs;
    repeat (19) @(negedge clk);
    check("slot3_mid_en", 32'(out_en), 32'(tbl[3].en));
    run = 1'b0;
    @(negedge clk);
    check_idle("drop_run");
    @(negedge clk);
    check_idle("stay_idle");
    run = 1'b1;
    @(negedge clk);
    check_idle("restart_dead0");
    @(negedge clk);
    check_idle("restart_dead1");
    @(negedge clk);
    check("restart_fs", 32'(frame_start), 1);
    check("restart_en", 32'(out_en), 32'(tbl[0].en));
    @(negedge clk);
    check("pre_rst_en", 32'(out_en), 32'(tbl[0].en));
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_fs;
    check_frame('0, -1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
